tx_mac: RTL
===========

Name: tx_mac

Overview:
- Ethernet MAC framer directly downstream of the IP transmit stage. It consumes the IP datagram byte stream (tuser marks the first byte) and emits a complete Ethernet II frame.
- Frame layout: preamble, SFD, destination MAC, source MAC, EtherType 0x0800, payload, zero padding to minimum length, CRC-32 FCS.
- After each frame it enforces an inter-frame gap. Output feeds the GMII/RGMII transmit adapter.

Parameters:
- MIN_PAYLOAD, 46: minimum payload bytes; shorter payloads are zero-padded up to this count.
- IFG_BYTES, 12: idle cycles after the last FCS byte before the next frame may start.
- ETH_TYPE, 16'h0800: EtherType inserted after the source MAC.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- mac_enable  in  1  1 = framing active; 0 = combinational bypass of the s_* signals to m_*.
- MAC_DestAddr  in  48  destination MAC, sent MSB byte first.
- MAC_SrcAddr  in  48  source MAC, sent MSB byte first.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tlast  in  1  last payload byte.
- s_axis_tuser  in  1  first byte of datagram.
- s_axis_tready  out  1  payload accept.
- m_axis_tdata  out  8  frame byte.
- m_axis_tvalid  out  1  frame byte valid.
- m_axis_tlast  out  1  last FCS byte.
- m_axis_tuser  out  1  first preamble byte.
- m_axis_tready  in  1  downstream accept.

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=8'h00; s_axis_tready=0.
  - CRC register=32'hFFFFFFFF; counters=0.
  - Reset mid-frame aborts the frame immediately; there is no tlast for the aborted frame.
- Output register:
  - m_* are registered. The register advances when (m_axis_tready | ~m_axis_tvalid). It holds all values while m_axis_tvalid & ~m_axis_tready.
- States: IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG.
- IDLE:
  - s_axis_tready = ~s_axis_tuser. Stray non-tuser bytes are accepted and discarded.
  - On s_axis_tvalid & s_axis_tuser: latch MAC_DestAddr and MAC_SrcAddr, go to PREAMBLE. The tuser byte is not consumed here.
  - First output byte is valid on the next clock, so latency is 1 cycle from tuser seen to preamble byte 0.
- PREAMBLE: 8 bytes, 7×8'h55 then 8'hD5. m_axis_tuser=1 on byte 0 only.
- DST, SRC, TYPE: 6, 6 and 2 bytes, MSB first. These bytes and all payload/pad bytes feed the CRC.
- PAYLOAD:
  - s_axis_tready = (m_axis_tready | ~m_axis_tvalid).
  - Each s_axis_tvalid & s_axis_tready transfer is copied to output; payload count increments, saturating at 16'hFFFF.
  - If s_axis_tvalid=0, the output shows a gap (tvalid=0). Upstream must supply contiguous data for line-rate use.
  - On an accepted byte with tlast:
    - if count+1 < MIN_PAYLOAD, go to PAD;
    - otherwise go to FCS.
- PAD: emit 8'h00 until count == MIN_PAYLOAD; s_axis_tready=0.
- FCS:
  - CRC-32 uses the reflected polynomial 0xEDB88320 with init 0xFFFFFFFF.
  - Byte-wise update is LSB-first and happens on each accepted output byte from DST through PAD.
  - FCS = ~CRC, sent bits [7:0] first through [31:24]. m_axis_tlast=1 on the 4th byte.
- IFG:
  - m_axis_tvalid=0 and s_axis_tready=0 for IFG_BYTES cycles, then IDLE.
  - The CRC and counters are re-initialised on entry to IDLE.
- Simultaneous events:
  - tuser asserted while in PAYLOAD is treated as ordinary data; no re-sync mid-frame.
  - tlast together with tuser on a single byte is a 1-byte payload and takes the PAD path.
- Width rules: count is 16 bit; comparisons against MIN_PAYLOAD are unsigned.
- Bypass: with mac_enable=0, m_* = s_* and s_axis_tready = m_axis_tready. The internal FSM is held in IDLE.

Test Plan:
- Minimum frame:
  - Stimulus: 20-byte payload 0x00..0x13 with tuser on byte 0 and tlast on byte 19; Dest=FF:FF:FF:FF:FF:FF; Src=00:0A:35:01:02:03.
  - Required: exactly 72 output bytes, as 8 preamble, 14 header, 20 data, 26 zero pad, 4 FCS.
  - Required: CRC residue over bytes 8..71 equals 32'hDEBB20E3; tlast only on byte 71.
- Long payload: 100 bytes. Required: no pad, total 8+14+100+4 = 126 bytes, FCS matching a software CRC-32 model.
- Backpressure: m_axis_tready toggled in a 1-0-0 pattern. Required: no byte dropped or duplicated, and m_axis_tdata stays stable while stalled.
- IFG: two back-to-back datagrams. Required: exactly 12 idle cycles between tlast and the next tuser; second frame preamble starts with 8'h55.
- Reset mid-frame: aresetn pulsed low at payload byte 10. Required: outputs go to reset values immediately, and the next datagram produces a correct frame.
- Bypass: mac_enable=0. Required: output equals input cycle-for-cycle, and tready follows m_axis_tready.

Source files
------------

// File: rtl/tx_mac.sv
// tx_mac: Ethernet II framer sitting after the IP transmit stage.
// Takes the IP datagram byte stream (s_axis_tuser marks the first byte) and
// emits preamble, SFD, destination MAC, source MAC, EtherType, payload,
// zero padding to MIN_PAYLOAD and the CRC-32 FCS. Enforces IFG_BYTES idle
// cycles after each frame.
//
// Ports:
//   s_axis_aclk, s_axis_aresetn : clock, asynchronous active-low reset
//   mac_enable                  : 1 = framing, 0 = combinational pass-through
//   MAC_DestAddr, MAC_SrcAddr   : 48-bit addresses, sent MSB byte first
//   s_axis_*                    : payload stream in (tdata/tvalid/tlast/tuser/tready)
//   m_axis_*                    : frame stream out (tdata/tvalid/tlast/tuser/tready)
module tx_mac #(
  parameter int          MIN_PAYLOAD = 46,
  parameter int          IFG_BYTES   = 12,
  parameter logic [15:0] ETH_TYPE    = 16'h0800
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        mac_enable,
  input  logic [47:0] MAC_DestAddr,
  input  logic [47:0] MAC_SrcAddr,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [16:0] MIN_P17  = 17'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state;
  logic [15:0] idx;
  logic [15:0] count;
  logic [31:0] crc;
  logic [47:0] dst_sr;
  logic [47:0] src_sr;

  // Output register stage
  logic [7:0]  data_p0;
  logic        vld_p0;
  logic        last_p0;
  logic        user_p0;

  logic        adv;
  logic [16:0] cnt_inc;
  logic [7:0]  type_byte;
  logic [7:0]  fcs_byte;
  logic [31:0] fcs;
  logic        ready_int;

  assign adv       = m_axis_tready | ~vld_p0;
  assign cnt_inc   = {1'b0, count} + 17'd1;
  assign type_byte = (idx == 16'd0) ? ETH_TYPE[15:8] : ETH_TYPE[7:0];
  assign fcs       = ~crc;

  always_comb begin
    fcs_byte = fcs[7:0];
    case (idx[1:0])
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  // In IDLE, stray non-tuser bytes are swallowed; the tuser byte waits for PAYLOAD.
  always_comb begin
    ready_int = 1'b0;
    if (!mac_enable) begin
      ready_int = m_axis_tready;
    end else begin
      case (state)
        IDLE:    ready_int = ~s_axis_tuser;
        PAYLOAD: ready_int = adv;
        default: ready_int = 1'b0;
      endcase
    end
  end

  assign s_axis_tready = ready_int & s_axis_aresetn;
  assign m_axis_tdata  = mac_enable ? data_p0 : s_axis_tdata;
  assign m_axis_tvalid = mac_enable ? vld_p0  : s_axis_tvalid;
  assign m_axis_tlast  = mac_enable ? last_p0 : s_axis_tlast;
  assign m_axis_tuser  = mac_enable ? user_p0 : s_axis_tuser;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state   <= IDLE;
      idx     <= 16'd0;
      count   <= 16'd0;
      crc     <= CRC_INIT;
      dst_sr  <= 48'd0;
      src_sr  <= 48'd0;
      data_p0 <= 8'h00;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      user_p0 <= 1'b0;
    end else if (!mac_enable) begin
      state   <= IDLE;
      idx     <= 16'd0;
      count   <= 16'd0;
      crc     <= CRC_INIT;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      user_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      user_p0 <= 1'b0;
      case (state)
        IDLE: begin
          // Preamble byte 0 goes straight into the output register.
          if (s_axis_tvalid && s_axis_tuser) begin
            dst_sr  <= MAC_DestAddr;
            src_sr  <= MAC_SrcAddr;
            data_p0 <= 8'h55;
            vld_p0  <= 1'b1;
            user_p0 <= 1'b1;
            idx     <= 16'd1;
            state   <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          data_p0 <= (idx == 16'd7) ? 8'hD5 : 8'h55;
          vld_p0  <= 1'b1;
          if (idx == 16'd7) begin
            idx   <= 16'd0;
            state <= DST;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        DST: begin
          data_p0 <= dst_sr[47:40];
          vld_p0  <= 1'b1;
          crc     <= crc_byte(crc, dst_sr[47:40]);
          dst_sr  <= {dst_sr[39:0], 8'h00};
          if (idx == 16'd5) begin
            idx   <= 16'd0;
            state <= SRC;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        SRC: begin
          data_p0 <= src_sr[47:40];
          vld_p0  <= 1'b1;
          crc     <= crc_byte(crc, src_sr[47:40]);
          src_sr  <= {src_sr[39:0], 8'h00};
          if (idx == 16'd5) begin
            idx   <= 16'd0;
            state <= TYPE;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        TYPE: begin
          data_p0 <= type_byte;
          vld_p0  <= 1'b1;
          crc     <= crc_byte(crc, type_byte);
          if (idx == 16'd1) begin
            idx   <= 16'd0;
            state <= PAYLOAD;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        PAYLOAD: begin
          // tuser here is plain data: no mid-frame resync.
          if (s_axis_tvalid) begin
            data_p0 <= s_axis_tdata;
            vld_p0  <= 1'b1;
            crc     <= crc_byte(crc, s_axis_tdata);
            count   <= sat_inc(count);
            if (s_axis_tlast) begin
              idx   <= 16'd0;
              state <= (cnt_inc < MIN_P17) ? PAD : FCS;
            end
          end
        end
        PAD: begin
          data_p0 <= 8'h00;
          vld_p0  <= 1'b1;
          crc     <= crc_byte(crc, 8'h00);
          count   <= sat_inc(count);
          if (cnt_inc >= MIN_P17) begin
            idx   <= 16'd0;
            state <= FCS;
          end
        end
        FCS: begin
          data_p0 <= fcs_byte;
          vld_p0  <= 1'b1;
          if (idx == 16'd3) begin
            last_p0 <= 1'b1;
            idx     <= 16'd0;
            state   <= IFG;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        IFG: begin
          // Counting starts once the last FCS byte has been taken.
          if (idx == IFG_LAST) begin
            idx   <= 16'd0;
            count <= 16'd0;
            crc   <= CRC_INIT;
            state <= IDLE;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
